instruction_ram: RTL and testbench

Parametrised, synchronous, writable program memory for the soft CPU. It replaces the hard-coded combinational instruction store.
- Read port: registered, with configurable latency and a valid flag. Fetches instructions by address.
- Write port: lets a loader, such as the UART downloader, place a program at run time.
- Initialisation: after reset, an internal sweep fills every location with the default instruction.

---
 rtl/instruction_ram_pkg.sv | 30 +++
 rtl/instruction_ram_core.sv | 27 ++
 rtl/instruction_ram.sv | 147 ++++++++++++++
 tb/tb_instruction_ram.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_ram_pkg.sv
// Shared definitions for the soft-CPU program memory: opcodes, the default instruction,
// FSM states and read-data source selects.
package instruction_ram_pkg;

  localparam int INSTR_WIDTH   = 28;
  localparam int OPERAND_WIDTH = 24;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LED  = 4'h1,
    OP_LOAD = 4'h2,
    OP_ADD  = 4'h3,
    OP_JMP  = 4'h4
  } opcode_e;

  // Cleared locations and out-of-range fetches return an LED instruction with a recognisable pattern.
  localparam logic [INSTR_WIDTH-1:0] DEFAULT_INSTR = {OP_LED, OPERAND_WIDTH'(24'b10101010)};

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  typedef enum logic [1:0] {
    SRC_DEFAULT,
    SRC_RAM,
    SRC_BYPASS
  } rd_src_e;

endpackage

// File: rtl/instruction_ram_core.sv
// Plain dual-port synchronous RAM: one write port, one read port with a 1-cycle registered read.
module instruction_ram_core #(
  parameter int DATA_WIDTH = 28,
  parameter int DEPTH      = 256,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // NOTE: no reset on the array or its output register, so the tools can map them onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instruction_ram.sv
// Writable program memory: power-up clear sweep, range-checked writes, write-first bypass,
// and a pipelined read path with latency 1 or 2.
module instruction_ram
  import instruction_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 28,
  parameter int                    ADDR_WIDTH   = 16,
  parameter int                    DEPTH        = 256,
  parameter int                    READ_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = DATA_WIDTH'(DEFAULT_INSTR)
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iReadEnable,
  input  logic [ADDR_WIDTH-1:0] iAddress,
  output logic [DATA_WIDTH-1:0] oInstruction,
  output logic                  oValid,
  input  logic                  iWriteEnable,
  input  logic [ADDR_WIDTH-1:0] iWriteAddress,
  input  logic [DATA_WIDTH-1:0] iWriteData,
  output logic                  oReady,
  output logic                  oWriteError
);

  localparam int                  AW      = $clog2(DEPTH);
  localparam logic [AW-1:0]       LAST    = AW'(DEPTH - 1);
  localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  state_e                state_q, state_d;
  logic [AW-1:0]         cnt_q, cnt_d;
  rd_src_e               src_q, src_d;
  logic [DATA_WIDTH-1:0] byp_q;
  logic                  valid1_q;
  logic                  werr_q;

  logic                  ready;
  logic                  rd_in_range, wr_in_range;
  logic                  rd_accept, wr_accept, wr_reject;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata, mem_rdata, data1;

  assign ready       = (state_q == ST_RUN);
  // Full-width compare: addresses at or beyond DEPTH never alias onto low locations.
  assign rd_in_range = ({1'b0, iAddress} < DEPTH_X);
  assign wr_in_range = ({1'b0, iWriteAddress} < DEPTH_X);
  assign rd_accept   = ready & iReadEnable;
  assign wr_accept   = ready & iWriteEnable & wr_in_range;
  assign wr_reject   = iWriteEnable & ~(ready & wr_in_range);

  // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_CLEAR;
    endcase
  end

  always_comb begin
    src_d = SRC_RAM;
    if (!rd_in_range) src_d = SRC_DEFAULT;
    else if (wr_accept && (iWriteAddress == iAddress)) src_d = SRC_BYPASS;
  end

  // The sweep owns the write port until the FSM reaches RUN.
  assign mem_we    = ~ready | wr_accept;
  assign mem_waddr = ready ? iWriteAddress[AW-1:0] : cnt_q;
  assign mem_wdata = ready ? iWriteData : DEFAULT_WORD;

  instruction_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_core (
    .clk_i   (Clock),
    .we_i    (mem_we),
    .waddr_i (mem_waddr),
    .wdata_i (mem_wdata),
    .re_i    (rd_accept & rd_in_range),
    .raddr_i (iAddress[AW-1:0]),
    .rdata_o (mem_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      src_q    <= SRC_DEFAULT;
      byp_q    <= '0;
      valid1_q <= 1'b0;
      werr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      valid1_q <= rd_accept;
      werr_q   <= wr_reject;
      if (rd_accept) begin
        src_q <= src_d;
        if (src_d == SRC_BYPASS) byp_q <= iWriteData;
      end
    end
  end

  // Source select only moves on an accepted read, so data1 holds between reads.
  always_comb begin
    data1 = DEFAULT_WORD;
    unique case (src_q)
      SRC_RAM:    data1 = mem_rdata;
      SRC_BYPASS: data1 = byp_q;
      default:    data1 = DEFAULT_WORD;
    endcase
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] data2_q;
      logic                  valid2_q;

      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          data2_q  <= DEFAULT_WORD;
          valid2_q <= 1'b0;
        end else begin
          valid2_q <= valid1_q;
          if (valid1_q) data2_q <= data1;
        end
      end

      assign oInstruction = data2_q;
      assign oValid       = valid2_q;
    end else begin : g_lat1
      assign oInstruction = data1;
      assign oValid       = valid1_q;
    end
  endgenerate

  assign oReady      = ready;
  assign oWriteError = werr_q;

endmodule

// File: tb/tb_instruction_ram.sv
// Directed bench for instruction_ram: latency-1 and latency-2 instances driven side by side.
module tb_instruction_ram;

  localparam logic [27:0] DEF = 28'h10000AA;

  logic        clk = 1'b0;
  logic        rst;
  logic        re, we;
  logic [15:0] raddr, waddr;
  logic [27:0] wdata;
  logic [27:0] instr1, instr2;
  logic        valid1, valid2, ready1, ready2, werr1, werr2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instruction_ram #(.READ_LATENCY(1)) dut1 (
    .Clock(clk), .Reset(rst), .iReadEnable(re), .iAddress(raddr),
    .oInstruction(instr1), .oValid(valid1), .iWriteEnable(we),
    .iWriteAddress(waddr), .iWriteData(wdata), .oReady(ready1), .oWriteError(werr1)
  );

  instruction_ram #(.READ_LATENCY(2)) dut2 (
    .Clock(clk), .Reset(rst), .iReadEnable(re), .iAddress(raddr),
    .oInstruction(instr2), .oValid(valid2), .iWriteEnable(we),
    .iWriteAddress(waddr), .iWriteData(wdata), .oReady(ready2), .oWriteError(werr2)
  );

  function automatic logic [27:0] exp_word(input int a);
    return 28'h2000000 + 28'(a * 17);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the clear sweep after reset release, counting edges until oReady.
  task automatic wait_sweep(input string tag);
    int edges = 0;
    for (int i = 1; i <= 400; i++) begin
      tick();
      if (ready1 && ready2) begin
        edges = i;
        break;
      end
    end
    n_checks++;
    if (edges !== 256) begin
      n_fail++;
      $display("FAIL %s sweep_len: got %0d edges, expected 256", tag, edges);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; re = 0; we = 0; raddr = 0; waddr = 0; wdata = 0;
    #2;
    n_checks++;
    if ({instr1, instr2} !== {DEF, DEF}) begin
      n_fail++;
      $display("FAIL reset_instr: got %h/%h, expected %h", instr1, instr2, DEF);
    end
    n_checks++;
    if ({valid1, valid2, ready1, ready2, werr1, werr2} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {valid1, valid2, ready1, ready2, werr1, werr2});
    end
  endtask

  task automatic test_clear_and_midsweep_reset();
    tick();
    rst = 1'b0;
    repeat (100) tick();
    we = 1; waddr = 16'd3; wdata = 28'h3333333; re = 1; raddr = 16'd3;
    tick();
    we = 0; re = 0;
    n_checks++;
    if ({werr1, werr2, valid1, ready1} !== 4'b1100) begin
      n_fail++;
      $display("FAIL clear_write_err: got werr/valid/ready %b, expected 1100",
               {werr1, werr2, valid1, ready1});
    end
    tick();
    n_checks++;
    if ({werr1, werr2, valid1, valid2} !== 4'b0000) begin
      n_fail++;
      $display("FAIL clear_err_pulse: got %b, expected 0000", {werr1, werr2, valid1, valid2});
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ready1, ready2, werr1} !== 3'b000) begin
      n_fail++;
      $display("FAIL midsweep_reset: got %b, expected 000", {ready1, ready2, werr1});
    end
    tick();
    rst = 1'b0;
    wait_sweep("restart");
    re = 1; raddr = 16'd3;
    tick();
    re = 0;
    n_checks++;
    if ({valid1, instr1} !== {1'b1, DEF}) begin
      n_fail++;
      $display("FAIL clear_write_dropped: got v=%b %h, expected v=1 %h", valid1, instr1, DEF);
    end
    tick();
  endtask

  task automatic test_default_reads();
    int addrs[3] = '{0, 100, 255};
    foreach (addrs[k]) begin
      re = 1; raddr = 16'(addrs[k]);
      tick();
      re = 0;
      n_checks++;
      if ({valid1, valid2, instr1} !== {2'b10, DEF}) begin
        n_fail++;
        $display("FAIL default_read_l1 @%0d: got v=%b%b %h, expected v=10 %h",
                 addrs[k], valid1, valid2, instr1, DEF);
      end
      tick();
      n_checks++;
      if ({valid1, valid2, instr2} !== {2'b01, DEF}) begin
        n_fail++;
        $display("FAIL default_read_l2 @%0d: got v=%b%b %h, expected v=01 %h",
                 addrs[k], valid1, valid2, instr2, DEF);
      end
    end
  endtask

  task automatic test_write_read();
    we = 1; waddr = 16'd5; wdata = 28'h1234567;
    tick();
    we = 0; re = 1; raddr = 16'd5;
    n_checks++;
    if (werr1 !== 1'b0) begin
      n_fail++;
      $display("FAIL write_ok_err: got %b, expected 0", werr1);
    end
    tick();
    re = 0;
    n_checks++;
    if ({valid1, instr1, valid2} !== {1'b1, 28'h1234567, 1'b0}) begin
      n_fail++;
      $display("FAIL write_read_l1: got v=%b %h v2=%b, expected v=1 1234567 v2=0",
               valid1, instr1, valid2);
    end
    tick();
    n_checks++;
    if ({valid2, instr2} !== {1'b1, 28'h1234567}) begin
      n_fail++;
      $display("FAIL write_read_l2: got v=%b %h, expected v=1 1234567", valid2, instr2);
    end
    n_checks++;
    if ({valid1, instr1} !== {1'b0, 28'h1234567}) begin
      n_fail++;
      $display("FAIL hold_l1: got v=%b %h, expected v=0 1234567", valid1, instr1);
    end
  endtask

  task automatic test_write_first();
    we = 1; waddr = 16'd7; wdata = 28'h0ABCDEF; re = 1; raddr = 16'd7;
    tick();
    we = 0; re = 0;
    n_checks++;
    if ({valid1, instr1} !== {1'b1, 28'h0ABCDEF}) begin
      n_fail++;
      $display("FAIL write_first_l1: got v=%b %h, expected v=1 0abcdef", valid1, instr1);
    end
    tick();
    n_checks++;
    if ({valid2, instr2} !== {1'b1, 28'h0ABCDEF}) begin
      n_fail++;
      $display("FAIL write_first_l2: got v=%b %h, expected v=1 0abcdef", valid2, instr2);
    end
  endtask

  task automatic test_out_of_range();
    we = 1; waddr = 16'd300; wdata = 28'h5555555;
    tick();
    we = 0;
    n_checks++;
    if ({werr1, werr2} !== 2'b11) begin
      n_fail++;
      $display("FAIL oor_write_err: got %b, expected 11", {werr1, werr2});
    end
    re = 1; raddr = 16'd300;
    tick();
    n_checks++;
    if ({werr1, valid1, instr1} !== {2'b01, DEF}) begin
      n_fail++;
      $display("FAIL oor_read_300: got err=%b v=%b %h, expected err=0 v=1 %h",
               werr1, valid1, instr1, DEF);
    end
    raddr = 16'd44;
    tick();
    re = 0;
    n_checks++;
    if ({valid1, instr1, valid2, instr2} !== {1'b1, DEF, 1'b1, DEF}) begin
      n_fail++;
      $display("FAIL no_alias_44: got %b %h / %b %h, expected 1 %h", valid1, instr1,
               valid2, instr2, DEF);
    end
    tick();
    n_checks++;
    if ({valid2, instr2} !== {1'b1, DEF}) begin
      n_fail++;
      $display("FAIL no_alias_44_l2: got v=%b %h, expected v=1 %h", valid2, instr2, DEF);
    end
  endtask

  task automatic test_back_to_back();
    bit          s_re[22];
    int          s_addr[22];
    logic [27:0] hold1 = DEF;
    logic [27:0] hold2 = DEF;
    for (int a = 0; a < 16; a++) begin
      we = 1; waddr = 16'(a); wdata = exp_word(a);
      tick();
    end
    we = 0;
    tick();
    for (int s = 0; s < 22; s++) begin
      s_re[s]   = (s < 16) || (s == 18) || (s == 19);
      s_addr[s] = (s < 16) ? s : ((s == 18) ? 3 : 12);
    end
    for (int s = 0; s < 22; s++) begin
      re = s_re[s]; raddr = 16'(s_addr[s]);
      tick();
      if (s_re[s]) hold1 = exp_word(s_addr[s]);
      n_checks++;
      if ({valid1, instr1} !== {s_re[s], hold1}) begin
        n_fail++;
        $display("FAIL stream_l1 slot %0d: got v=%b %h, expected v=%b %h",
                 s, valid1, instr1, s_re[s], hold1);
      end
      if (s >= 1) begin
        if (s_re[s-1]) hold2 = exp_word(s_addr[s-1]);
        n_checks++;
        if ({valid2, instr2} !== {s_re[s-1], hold2}) begin
          n_fail++;
          $display("FAIL stream_l2 slot %0d: got v=%b %h, expected v=%b %h",
                   s - 1, valid2, instr2, s_re[s-1], hold2);
        end
      end
    end
    re = 0;
  endtask

  task automatic test_run_reset();
    re = 1; raddr = 16'd2;
    tick();
    re = 0;
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({ready1, ready2, valid1, valid2, instr1, instr2} !== {4'b0000, DEF, DEF}) begin
      n_fail++;
      $display("FAIL run_reset_async: got rdy=%b%b v=%b%b %h/%h, expected 0000 %h",
               ready1, ready2, valid1, valid2, instr1, instr2, DEF);
    end
    tick();
    rst = 1'b0;
    wait_sweep("run_reset");
    re = 1; raddr = 16'd5;
    tick();
    re = 0;
    n_checks++;
    if ({valid1, instr1} !== {1'b1, DEF}) begin
      n_fail++;
      $display("FAIL reswept_5: got v=%b %h, expected v=1 %h", valid1, instr1, DEF);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_clear_and_midsweep_reset();
    test_default_reads();
    test_write_read();
    test_write_first();
    test_out_of_range();
    test_back_to_back();
    test_run_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
